// File: rtl/uart_msg_reader.sv
// Walks a block of the message ROM from BASE_ADDR and hands each byte to the UART
// transmitter over valid/ready, ending after MSG_LEN bytes or (optionally) at a NUL.
module uart_msg_reader #(
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned MSG_LEN     = 512,
    parameter bit          STOP_ON_NUL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    output logic [8:0] o_rom_addr,
    input  logic [7:0] i_rom_data,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic [9:0] o_count
);

    localparam logic [8:0] BASE = 9'(BASE_ADDR);
    localparam logic [9:0] LEN  = 10'(MSG_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] addr_q,  addr_d;
    logic [7:0] data_q,  data_d;
    logic       valid_q, valid_d;
    logic [9:0] count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= BASE;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            count_q <= 10'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                addr_d = BASE;
                if (i_start) begin
                    count_d = 10'd0;
                    state_d = S_FETCH;
                end
            end
            // ROM captures addr_q on the edge leaving FETCH; its data is visible in WAIT.
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (STOP_ON_NUL && (i_rom_data == 8'h00)) begin
                    state_d = S_DONE;
                end else begin
                    data_d  = i_rom_data;
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (valid_q && i_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + 10'd1;
                    if ((count_q + 10'd1) == LEN) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 9'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                addr_d  = BASE;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_rom_addr = addr_q;
    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_count    = count_q;
    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = (state_q == S_DONE);

endmodule
